digit_shift_reg: RTL
====================

Name: digit_shift_reg

Overview:
- Parametrised digit-wide shift register; successor to the fixed 32-bit, 4-bit-nibble shifter used in the display/data path.
- Shifts whole digits left or right with serial digit insert, rotates, parallel-loads, and clears.
- Tracks how many valid digits are held and reports each valid digit pushed out of the end.
- Sits between the keypad/serial digit source and the display or datapath consumer.

Parameters:
- DIGIT_W, 4, bits per digit.
- DEPTH, 8, number of digits held; DEPTH >= 2.
- CNT_W, $clog2(DEPTH+1), width of the fill count (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- en  in  1  operation enable; 0 = hold.
- mode  in  3  operation select (encoding below).
- rin  in  DIGIT_W  digit inserted at the MS end on shift right.
- lin  in  DIGIT_W  digit inserted at the LS end on shift left.
- pload  in  DIGIT_W*DEPTH  parallel load value.
- qout  out  DIGIT_W*DEPTH  register contents; digit 0 = bits [DIGIT_W-1:0].
- count  out  CNT_W  number of valid digits, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- shift_out  out  DIGIT_W  digit displaced by the last shift or rotate.
- out_valid  out  1  one-cycle pulse: shift_out is a valid digit discarded by a shift.

Behaviour:
- Reset: clr=1 at a clk edge gives qout=0, count=0, shift_out=0, out_valid=0. clr overrides en and mode. Reset mid-operation discards everything.
- All outputs are registered. Effects appear the cycle after the sampling edge.
- full and empty decode the registered count, so they update in the same cycle as count.
- en=0: no state change; out_valid=0; shift_out holds.
- Modes (en=1):
  - 000 hold: no change, out_valid=0.
  - 001 shift right: qout <= {rin, qout[top:DIGIT_W]}; shift_out <= old digit 0; count <= min(count+1, DEPTH); out_valid <= (old count == DEPTH).
  - 010 shift left: qout <= {qout[top-DIGIT_W:0], lin}; shift_out <= old digit DEPTH-1; count as for shift right; out_valid as for shift right.
  - 011 rotate right: digit 0 moves to digit DEPTH-1; shift_out <= old digit 0; count unchanged; out_valid=0.
  - 100 rotate left: digit DEPTH-1 moves to digit 0; shift_out <= old digit DEPTH-1; count unchanged; out_valid=0.
  - 101 parallel load: qout <= pload; count <= DEPTH; out_valid=0; shift_out holds.
  - 110 sync clear: qout <= 0; count <= 0; out_valid=0; shift_out holds.
  - 111 reserved: treat as hold.
- Count saturates at DEPTH and never wraps. Shifting while full keeps count=DEPTH and pulses out_valid on every shift.
- When not full, displaced digits are fill zeros: shift_out still updates, out_valid=0.
- Digits are atomic. There is no partial-digit shifting and no sub-digit arithmetic.
- No X or Z is ever driven. All outputs are defined after the first reset.

Decomposition:
- Shared package digit_pkg holds:
  - mode localparams MODE_HOLD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_LOAD, MODE_CLR;
  - the default DIGIT_W.
- One sub-module is natural: digit_fill_counter (saturating 0..DEPTH up-counter with load-to-max, clear, and full/empty decode). The data path stays in the top module.

Test Plan (DIGIT_W=4, DEPTH=8):
- Reset then 8 shift-right cycles with rin=1..8 -> qout=0x87654321, count=8, full=1, out_valid=0 throughout.
- From that state, shift right with rin=9 -> qout=0x98765432, shift_out=1, out_valid=1 for exactly one cycle, count stays 8.
- Load pload=0x12345678, then rotate left twice -> 0x23456781 then 0x34567812; count=8; out_valid=0; shift_out=1 then 2.
- Reset, shift left lin=A three times -> qout=0x00000AAA, count=3, empty=0, full=0, out_valid never 1.
- en=0 with mode=001 for 5 cycles -> qout, count and shift_out unchanged, out_valid=0.
- Mid-sequence, assert clr together with mode=101 -> next cycle qout=0, count=0, empty=1; mode 110 after a load gives the same result but leaves shift_out unchanged.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared definitions for the digit shift register: operation encodings
// and the default digit width.
package digit_pkg;

    localparam int DIGIT_W_DEF = 4;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
    localparam logic [2:0] MODE_CLR  = 3'b110;

endpackage

// File: rtl/digit_fill_counter.sv
// Saturating 0..DEPTH occupancy counter with load-to-max and clear,
// plus registered-count full/empty decode.
module digit_fill_counter #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    input  logic             load_max,
    input  logic             sclr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (sclr) begin
            count_d = '0;
        end else if (load_max) begin
            count_d = MAX;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign full  = (count_q == MAX);
    assign empty = (count_q == '0);

endmodule

// File: rtl/digit_shift_reg.sv
// Digit-granular shift/rotate/load register with fill tracking and a
// pulse for each valid digit pushed out of a full register.
module digit_shift_reg
    import digit_pkg::*;
#(
    parameter  int DIGIT_W = DIGIT_W_DEF,
    parameter  int DEPTH   = 8,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic [DIGIT_W-1:0]       rin,
    input  logic [DIGIT_W-1:0]       lin,
    input  logic [DIGIT_W*DEPTH-1:0] pload,
    output logic [DIGIT_W*DEPTH-1:0] qout,
    output logic [CNT_W-1:0]         count,
    output logic                     full,
    output logic                     empty,
    output logic [DIGIT_W-1:0]       shift_out,
    output logic                     out_valid
);

    localparam int TOP = DIGIT_W * DEPTH - 1;

    logic [TOP:0]         qout_q, qout_d;
    logic [DIGIT_W-1:0]   shift_out_q, shift_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 cnt_inc, cnt_load, cnt_clr;

    always_comb begin
        qout_d      = qout_q;
        shift_out_d = shift_out_q;
        out_valid_d = 1'b0;
        cnt_inc     = 1'b0;
        cnt_load    = 1'b0;
        cnt_clr     = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: ;
                MODE_SHR: begin
                    qout_d      = {rin, qout_q[TOP:DIGIT_W]};
                    shift_out_d = qout_q[DIGIT_W-1:0];
                    out_valid_d = full;
                    cnt_inc     = 1'b1;
                end
                MODE_SHL: begin
                    qout_d      = {qout_q[TOP-DIGIT_W:0], lin};
                    shift_out_d = qout_q[TOP -: DIGIT_W];
                    out_valid_d = full;
                    cnt_inc     = 1'b1;
                end
                MODE_ROR: begin
                    qout_d      = {qout_q[DIGIT_W-1:0], qout_q[TOP:DIGIT_W]};
                    shift_out_d = qout_q[DIGIT_W-1:0];
                end
                MODE_ROL: begin
                    qout_d      = {qout_q[TOP-DIGIT_W:0], qout_q[TOP -: DIGIT_W]};
                    shift_out_d = qout_q[TOP -: DIGIT_W];
                end
                MODE_LOAD: begin
                    qout_d   = pload;
                    cnt_load = 1'b1;
                end
                MODE_CLR: begin
                    qout_d  = '0;
                    cnt_clr = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            qout_q      <= '0;
            shift_out_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            qout_q      <= qout_d;
            shift_out_q <= shift_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    digit_fill_counter #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .clr      (clr),
        .inc      (cnt_inc),
        .load_max (cnt_load),
        .sclr     (cnt_clr),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign qout      = qout_q;
    assign shift_out = shift_out_q;
    assign out_valid = out_valid_q;

endmodule
